// File: rtl/mac_step3.sv
// Three-stage fused multiply-add back end: aligns a pre-multiplied product with a
// single-precision addend and packs the sum. Define MAC_STEP3_RNE_EN for round-to-nearest-even.
module mac_step3 #(
  parameter int LAT = 3
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_ex,
  input  logic [21:0] mul_out,
  input  logic [4:0]  count,
  input  logic [31:0] in_C,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  logic           adv;
  logic [LAT:0]   vld;

  assign in_ready  = !(out_valid && !out_ready);
  assign adv       = in_ready;
  assign out_valid = vld[LAT];

  // Input capture
  logic        r_sign;
  logic [7:0]  r_ex;
  logic [21:0] r_mul;
  logic [4:0]  r_cnt;
  logic [31:0] r_c;

  // NOTE: data registers carry no reset; only valid bits and the visible outputs need a defined value.
  always_ff @(posedge CLK) begin
    if (adv && in_valid) begin
      // NOTE: non-blocking assignments so every stage samples the values from before the edge.
      r_sign <= in_sign;
      r_ex   <= in_ex;
      r_mul  <= mul_out;
      r_cnt  <= count;
      r_c    <= in_C;
    end
  end

  // Stage 1: left-justify the product, unpack C, detect bypass cases
  logic [7:0]  c_exp;
  logic        c_zero, c_special;
  logic [9:0]  s1_ep_n;
  logic [23:0] s1_pm_n, s1_cm_n;
  logic        s1_byp_n;
  logic [31:0] s1_bv_n;

  always_comb begin
    // NOTE: every signal of a combinational block gets a value on every path, so no latch is inferred.
    c_exp     = r_c[30:23];
    c_zero    = (c_exp == 8'd0);
    c_special = (c_exp == 8'hFF);
    s1_ep_n   = {2'b00, r_ex} + {5'd0, r_cnt} - 10'd20;
    s1_pm_n   = {2'b00, r_mul} << (5'd23 - r_cnt);
    s1_cm_n   = c_zero ? 24'd0 : {1'b1, r_c[22:0]};
    s1_byp_n  = c_special || (r_mul == 22'd0) || ($signed(s1_ep_n) <= 10'sd0);
    s1_bv_n   = c_zero ? {r_c[31], 31'd0} : r_c;
  end

  logic        s1_byp, s1_ps, s1_cs;
  logic [31:0] s1_bv;
  logic [9:0]  s1_ep;
  logic [23:0] s1_pm, s1_cm;
  logic [7:0]  s1_ce;

  always_ff @(posedge CLK) begin
    if (adv) begin
      s1_byp <= s1_byp_n;
      s1_bv  <= s1_bv_n;
      s1_ps  <= r_sign;
      s1_ep  <= s1_ep_n;
      s1_pm  <= s1_pm_n;
      s1_cs  <= r_c[31];
      s1_ce  <= c_exp;
      s1_cm  <= s1_cm_n;
    end
  end

  // Stage 2: order by magnitude, align with guard/round/sticky, add or subtract
  logic        p_big, sa, sb;
  logic [9:0]  ea, eb, d;
  logic [23:0] ma, mb;
  logic [26:0] op_a, op_b, shf, mask, al;
  logic        stk;
  logic [27:0] sum_n;

  always_comb begin
    p_big = {s1_ep, s1_pm} >= {2'b00, s1_ce, s1_cm};
    ea    = p_big ? s1_ep : {2'b00, s1_ce};
    eb    = p_big ? {2'b00, s1_ce} : s1_ep;
    ma    = p_big ? s1_pm : s1_cm;
    mb    = p_big ? s1_cm : s1_pm;
    sa    = p_big ? s1_ps : s1_cs;
    sb    = p_big ? s1_cs : s1_ps;
    d     = ea - eb;
    op_a  = {ma, 3'b000};
    op_b  = {mb, 3'b000};
    shf   = op_b >> d;
    mask  = (27'd1 << d) - 27'd1;
    stk   = |(op_b & mask);
    if (d >= 10'd27) al = {26'd0, |mb};
    else             al = {shf[26:1], shf[0] | stk};
    sum_n = (sa ^ sb) ? ({1'b0, op_a} - {1'b0, al}) : ({1'b0, op_a} + {1'b0, al});
  end

  logic        s2_byp, s2_sign;
  logic [31:0] s2_bv;
  logic [9:0]  s2_exp;
  logic [27:0] s2_sum;

  always_ff @(posedge CLK) begin
    if (adv) begin
      s2_byp  <= s1_byp;
      s2_bv   <= s1_bv;
      s2_sign <= sa;
      s2_exp  <= ea;
      s2_sum  <= sum_n;
    end
  end

  // Stage 3: normalize, round, renormalize on carry, pack
  logic [4:0]  lz;
  logic [27:0] norm;
  logic [10:0] e_n, e_r;
  logic [23:0] mant;
  logic [24:0] mant_r;
  logic [22:0] frac;
  logic        inx, rup;
  logic [31:0] res_n;
  logic [2:0]  fl_n;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 28; i++) begin
      if (s2_sum[i]) lz = 5'(27 - i);
    end
    norm = s2_sum << lz;
    e_n  = {s2_exp[9], s2_exp} + 11'd1 - {6'd0, lz};
    mant = norm[27:4];
    inx  = |norm[3:0];
`ifdef MAC_STEP3_RNE_EN
    rup  = norm[3] & ((|norm[2:0]) | norm[4]);
`else
    rup  = 1'b0;
`endif
    mant_r = {1'b0, mant} + {24'd0, rup};
    e_r    = e_n + {10'd0, mant_r[24]};
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    res_n = {s2_sign, e_r[7:0], frac};
    fl_n  = {2'b00, inx};
    if (s2_byp) begin
      res_n = s2_bv;
      fl_n  = 3'b000;
    end else if (s2_sum == 28'd0) begin
      res_n = 32'd0;
      fl_n  = 3'b000;
    end else if ($signed(e_r) >= 11'sd255) begin
      res_n = {s2_sign, 8'hFF, 23'd0};
      fl_n  = 3'b101;
    end else if ($signed(e_r) <= 11'sd0) begin
      res_n = {s2_sign, 31'd0};
      fl_n  = 3'b011;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vld    <= '0;
      result <= 32'd0;
      flags  <= 3'b000;
    end else if (adv) begin
      vld    <= {vld[LAT-1:0], in_valid};
      result <= res_n;
      flags  <= fl_n;
    end
  end

endmodule

// File: tb/tb_mac_step3.sv
// Scoreboard bench for mac_step3: directed beats push expected results, a monitor pops on output.
module tb_mac_step3;

  logic        CLK = 1'b0;
  logic        RESETn, in_valid, in_ready, in_sign, out_valid, out_ready;
  logic [7:0]  in_ex;
  logic [21:0] mul_out;
  logic [4:0]  count;
  logic [31:0] in_C, result;
  logic [2:0]  flags;

  always #5 CLK = ~CLK;

  mac_step3 #(.LAT(3)) dut (
    .CLK(CLK), .RESETn(RESETn), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_ex(in_ex), .mul_out(mul_out), .count(count), .in_C(in_C),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  fl;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0, n_errors = 0, n_out = 0, n_exp = 0, n_disc = 0;

`ifdef MAC_STEP3_RNE_EN
  localparam logic [31:0] RND_SMALL = 32'h3F800001;
  localparam logic [31:0] RND_CARRY = 32'h3F800000;
`else
  localparam logic [31:0] RND_SMALL = 32'h3F800000;
  localparam logic [31:0] RND_CARRY = 32'h3F7FFFFF;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send(input logic s, input logic [7:0] ex, input logic [21:0] m,
                      input logic [4:0] c, input logic [31:0] cv,
                      input logic [31:0] er, input logic [2:0] ef);
    int n = 0;
    exp_t e;
    @(negedge CLK);
    in_valid = 1'b1; in_sign = s; in_ex = ex; mul_out = m; count = c; in_C = cv;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge CLK); #1; n++;
    end
    if (!in_ready) begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      e.res = er; e.fl = ef;
      sb_q.push_back(e);
      n_exp++;
      @(posedge CLK);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge CLK); n++;
    end
  endtask

  // Monitor: pops on each transfer, checks held output during back-pressure
  always @(negedge CLK) begin
    exp_t e;
    if (RESETn && out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else if (out_ready) begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("flags", {29'd0, flags}, {29'd0, e.fl});
        n_out++;
      end else begin
        check("hold_result", result, sb_q[0].res);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    RESETn = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_ex = 8'd0;
    mul_out = 22'd0; count = 5'd0; in_C = 32'd0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, flags}, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RESETn = 1'b1;

    // 1.0 + 1.0 with explicit latency check
    send(0, 8'd127, 22'h100000, 5'd20, 32'h3F800000, 32'h40000000, 3'b000);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("latency_early", {31'd0, out_valid}, 32'd0);
    end
    @(negedge CLK);
    check("latency_n3", {31'd0, out_valid}, 32'd1);

    send(0, 8'd127, 22'h100000, 5'd20, 32'hBF800000, 32'h00000000, 3'b000); // cancellation
    send(0, 8'd127, 22'h300000, 5'd21, 32'h00000000, 32'h40400000, 3'b000); // 3.0 + 0
    send(0, 8'd254, 22'h300000, 5'd21, 32'h7F7FFFFF, 32'h7F800000, 3'b101); // overflow
    send(0, 8'd127, 22'h000000, 5'd21, 32'hC1200000, 32'hC1200000, 3'b000); // zero product
    send(0, 8'd127, 22'h100000, 5'd20, 32'h33C00000, RND_SMALL,    3'b001); // rounding
    send(0, 8'd101, 22'h300000, 5'd21, 32'h3F7FFFFF, RND_CARRY,    3'b001); // round carry-out
    send(0, 8'd127, 22'h100000, 5'd20, 32'hB3C00000, 32'h3F7FFFFE, 3'b001); // subtract, tie
    send(0, 8'd127, 22'h100000, 5'd20, 32'h7F800000, 32'h7F800000, 3'b000); // +Inf C
    send(1, 8'd127, 22'h100000, 5'd20, 32'hFFC00001, 32'hFFC00001, 3'b000); // NaN C
    send(0, 8'd127, 22'h100000, 5'd20, 32'h00000001, 32'h3F800000, 3'b000); // denormal C flushed
    send(0, 8'd127, 22'h000000, 5'd21, 32'h80000001, 32'h80000000, 3'b000); // zero + denormal
    send(0, 8'd1,   22'h100000, 5'd20, 32'h80C00000, 32'h80000000, 3'b011); // underflow
    send(1, 8'd127, 22'h100000, 5'd20, 32'h00000000, 32'hBF800000, 3'b000); // negative product
    send(0, 8'd0,   22'h100000, 5'd20, 32'h40490FDB, 32'h40490FDB, 3'b000); // ep<=0 product
    send(1, 8'd127, 22'h000000, 5'd21, 32'h00000000, 32'h00000000, 3'b000); // -0 + +0
    drain();

    // Stall: four streamed beats, three cycles of back-pressure
    fork
      begin
        send(0, 8'd127, 22'h100000, 5'd20, 32'h3F800000, 32'h40000000, 3'b000);
        send(0, 8'd127, 22'h300000, 5'd21, 32'h00000000, 32'h40400000, 3'b000);
        send(0, 8'd254, 22'h300000, 5'd21, 32'h7F7FFFFF, 32'h7F800000, 3'b101);
        send(0, 8'd127, 22'h000000, 5'd21, 32'hC1200000, 32'hC1200000, 3'b000);
      end
      begin
        n = 0;
        while (!out_valid && n < 40) begin
          @(negedge CLK); n++;
        end
        @(posedge CLK); #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge CLK);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge CLK); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight and a result waiting at the output
    @(posedge CLK); #1 out_ready = 1'b0;
    send(0, 8'd127, 22'h100000, 5'd20, 32'h3F800000, 32'h40000000, 3'b000);
    send(0, 8'd127, 22'h300000, 5'd21, 32'h00000000, 32'h40400000, 3'b000);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge CLK); n++;
    end
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #1 RESETn = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_result", result, 32'd0);
    n_disc = sb_q.size();
    sb_q.delete();
    @(negedge CLK);
    RESETn = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(negedge CLK);

    check("sb_empty", sb_q.size(), 32'd0);
    check("delivered", n_out, n_exp - n_disc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
